// File: rtl/multi_digit_display_pkg.sv
// Shared segment patterns, digit encoder and conversion FSM encoding for the
// multi-digit display. Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package multi_digit_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one bit per clock, VALUE_W clocks.
// done_o marks the cycle in which the final shift happens; bcd_o holds afterwards.
module bin2bcd_seq
  import multi_digit_display_pkg::*;
#(
  parameter int VALUE_W    = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    start_i,
  input  logic [VALUE_W-1:0]      value_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [VALUE_W-1:0] bin_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // The caller saturates the input, so nothing non-zero ever leaves the top BCD nibble.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i && !busy_q) begin
      bcd_q  <= '0;
      bin_q  <= value_i;
      cnt_q  <= CNT_W'(VALUE_W - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == '0);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/multi_digit_display.sv
// N-digit multiplexed seven-segment driver: captures a value, converts it to BCD,
// and scans digits on the refresh strobe with leading-zero blanking and blinking.
module multi_digit_display
  import multi_digit_display_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int VALUE_W       = 14,
  parameter int BLANK_LEADING = 1,
  parameter int BLINK_DIV     = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  clk_display,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic                  blink_en,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = $clog2(BLINK_DIV + 1);
  localparam logic [VALUE_W-1:0] MAX_VAL = VALUE_W'(10**NUM_DIGITS - 1);

  conv_state_e           state_q;
  logic                  pend_v_q;
  logic [VALUE_W-1:0]    pend_val_q;
  logic                  ovf_fly_q;
  logic                  overflow_q;
  logic [BCD_W-1:0]      disp_q;
  logic [IDX_W-1:0]      idx_q;
  logic [BLK_W-1:0]      blink_cnt_q;
  logic                  blink_off_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;

  logic               eng_start;
  logic [VALUE_W-1:0] src_val;
  logic [VALUE_W-1:0] eng_value;
  logic               src_ovf;
  logic               eng_busy;
  logic               eng_done;
  logic [BCD_W-1:0]   eng_bcd;

  // A load arriving during COMMIT takes priority over the older pending value.
  always_comb begin
    src_val   = value;
    eng_start = 1'b0;
    if (state_q == ST_IDLE) begin
      eng_start = load;
    end else if (state_q == ST_COMMIT) begin
      eng_start = load | pend_v_q;
      if (!load) begin
        src_val = pend_val_q;
      end
    end
    eng_start = eng_start & ~eng_busy;
  end

  assign src_ovf   = (src_val > MAX_VAL);
  assign eng_value = src_ovf ? MAX_VAL : src_val;

  bin2bcd_seq #(
    .VALUE_W    (VALUE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .arst_n  (arst_n),
    .start_i (eng_start),
    .value_i (eng_value),
    .busy_o  (eng_busy),
    .done_o  (eng_done),
    .bcd_o   (eng_bcd)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      pend_v_q   <= 1'b0;
      pend_val_q <= '0;
      ovf_fly_q  <= 1'b0;
      overflow_q <= 1'b0;
      disp_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (eng_start) begin
            state_q   <= ST_SHIFT;
            ovf_fly_q <= src_ovf;
          end
        end
        ST_SHIFT: begin
          if (load) begin
            pend_v_q   <= 1'b1;
            pend_val_q <= value;
          end
          if (eng_done) begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          disp_q     <= eng_bcd;
          overflow_q <= ovf_fly_q;
          pend_v_q   <= 1'b0;
          if (eng_start) begin
            state_q   <= ST_SHIFT;
            ovf_fly_q <= src_ovf;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // lead_zero[i] is set when digits i..NUM_DIGITS-1 of the display register are all zero.
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;
  logic [3:0]            cur_digit;
  logic                  cur_blank;

  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (disp_q[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
    end
  end

  assign cur_digit = disp_q[4*idx_q +: 4];
  assign cur_blank = (BLANK_LEADING != 0) && (idx_q != '0) && lead_zero[idx_q];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
    end else if (clk_display) begin
      idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        blink_off_q <= ~blink_off_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLK_W'(1);
      end
      if (blink_en && blink_off_q) begin
        an_q  <= '1;
        seg_q <= SEG_BLANK;
      end else begin
        an_q  <= ~(NUM_DIGITS'(1) << idx_q);
        seg_q <= cur_blank ? SEG_BLANK : seg_encode(cur_digit);
      end
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign overflow = overflow_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_multi_digit_display.sv
// Directed and randomized checks of multi_digit_display against an arithmetic
// model of the digits, blanking, scan order and blink phase.
module tb_multi_digit_display;

  localparam int N     = 4;
  localparam int VW    = 14;
  localparam int BLINK = 2;
  localparam int MAXV  = 9999;

  logic          clk;
  logic          arst_n;
  logic          clk_display;
  logic [VW-1:0] value;
  logic          load;
  logic          blink_en;
  logic          busy;
  logic          overflow;
  logic [N-1:0]  an;
  logic [6:0]    seg;

  int nChecks = 0;
  int nFails  = 0;
  int modelVal = 0;
  int tbIdx = 0;
  int tickCount = 0;

  logic [6:0] segTable [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  multi_digit_display #(
    .NUM_DIGITS    (N),
    .VALUE_W       (VW),
    .BLANK_LEADING (1),
    .BLINK_DIV     (BLINK)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .clk_display (clk_display),
    .value       (value),
    .load        (load),
    .blink_en    (blink_en),
    .busy        (busy),
    .overflow    (overflow),
    .an          (an),
    .seg         (seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] refSeg(input int v, input int idx);
    int sat;
    int p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    sat = (v > MAXV) ? MAXV : v;
    if (idx > 0 && sat < p) return 7'h7F;
    return segTable[(sat / p) % 10];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int v);
    value = VW'(v);
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy && n < 64) begin
      step();
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic displayTick(input string tag);
    int       expIdx;
    bit       expOff;
    logic [3:0] expAn;
    expIdx = tbIdx;
    expOff = blink_en && (((tickCount / BLINK) % 2) == 1);
    clk_display = 1'b1;
    step();
    clk_display = 1'b0;
    tbIdx = (tbIdx + 1) % N;
    tickCount++;
    expAn = expOff ? 4'hF : ~(4'b0001 << expIdx);
    checkOutput({tag, "_an"}, 32'(an), 32'(expAn));
    if (!expOff) checkOutput({tag, "_seg"}, 32'(seg), 32'(refSeg(modelVal, expIdx)));
  endtask

  task automatic scanAll(input string tag);
    repeat (N) displayTick(tag);
  endtask

  initial begin
    int vals [10];
    arst_n      = 1'b0;
    clk_display = 1'b0;
    value       = '0;
    load        = 1'b0;
    blink_en    = 1'b0;
    repeat (3) step();
    checkOutput("reset_an", 32'(an), 32'hF);
    checkOutput("reset_seg", 32'(seg), 32'h7F);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ovf", 32'(overflow), 32'd0);
    arst_n = 1'b1;
    step();

    $display("[TB] latency and leading-zero blanking");
    applyStimulus(42);
    for (int k = 0; k < 15; k++) begin
      checkOutput("lat_busy", 32'(busy), 32'd1);
      step();
    end
    checkOutput("lat_done", 32'(busy), 32'd0);
    modelVal = 42;
    scanAll("v42");

    $display("[TB] reset during conversion");
    applyStimulus(1234);
    repeat (4) step();
    #2 arst_n = 1'b0;
    #1;
    checkOutput("rstmid_an", 32'(an), 32'hF);
    checkOutput("rstmid_seg", 32'(seg), 32'h7F);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    repeat (2) step();
    arst_n    = 1'b1;
    modelVal  = 0;
    tbIdx     = 0;
    tickCount = 0;
    step();
    checkOutput("rstmid_idle", 32'(busy), 32'd0);
    scanAll("after_rst");
    displayTick("wrap");

    $display("[TB] overflow saturation and recovery");
    applyStimulus(12000);
    waitIdle("ovf");
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    modelVal = 12000;
    scanAll("ovf");
    applyStimulus(7);
    waitIdle("ovf_clr");
    checkOutput("ovf_clear", 32'(overflow), 32'd0);
    modelVal = 7;
    scanAll("v7");

    $display("[TB] pending load, newest wins");
    applyStimulus(111);
    for (int k = 0; k < 30; k++) begin
      checkOutput("pend_busy", 32'(busy), 32'd1);
      if (k == 2 || k == 5) begin
        value = (k == 2) ? VW'(222) : VW'(333);
        load  = 1'b1;
      end
      if (k == 20) begin
        modelVal = 111;
        displayTick("pend_first");
      end else begin
        step();
      end
      load = 1'b0;
    end
    checkOutput("pend_done", 32'(busy), 32'd0);
    modelVal = 333;
    scanAll("pend_second");

    $display("[TB] refresh coincident with commit");
    applyStimulus(5678);
    repeat (14) step();
    checkOutput("conf_busy", 32'(busy), 32'd1);
    displayTick("conf_old");
    modelVal = 5678;
    displayTick("conf_new");
    checkOutput("conf_idle", 32'(busy), 32'd0);

    $display("[TB] blinking");
    blink_en = 1'b1;
    repeat (8) displayTick("blink");
    blink_en = 1'b0;
    repeat (4) displayTick("noblink");

    $display("[TB] boundary and random values");
    vals[0] = 0;
    vals[1] = MAXV;
    vals[2] = MAXV + 1;
    vals[3] = 16383;
    for (int i = 4; i < 10; i++) vals[i] = int'($urandom_range(0, 16383));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vals[i]);
      waitIdle("rnd");
      checkOutput("rnd_ovf", 32'(overflow), (vals[i] > MAXV) ? 32'd1 : 32'd0);
      modelVal = vals[i];
      scanAll("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
